// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   Arbitrates a shared AHB between IAHB (0), DAHB (1) and an auxiliary
//   master (2). Re-arbitrates only when HREADY is high, honours locked
//   sequences, and limits how long an unlocked owner may keep the bus while
//   others wait (MAX_HOLD quota).
//
//   Optional feature: define AHB_ARB_ROUND_ROBIN_EN to make the hand-over
//   search start after the current owner (round robin). Without it, the
//   lowest requesting index wins (fixed priority).
//
// Ports
//   HCLK          bus clock
//   HRESET        synchronous active-high reset
//   HBUSREQ[N]    per-master bus request
//   HLOCK[N]      per-master locked-transfer request
//   HREADY        transfer-done; high marks an arbitration point
//   HGRANT[N]     one-hot grant (decode of registered grant index)
//   HMASTER       owner of the current address phase
//   HMASTER_DATA  owner of the current data phase
//   HMASTLOCK     current address phase is locked
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int MIDX_W         = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MIDX_W-1:0]      HMASTER,
    output logic [MIDX_W-1:0]      HMASTER_DATA,
    output logic                   HMASTLOCK
);

    localparam logic [MIDX_W-1:0] DEF_IDX  = MIDX_W'(DEFAULT_MASTER);
    localparam logic [7:0]        HOLD_MAX = 8'(MAX_HOLD - 1);

    logic [MIDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [MIDX_W-1:0] hmaster_q;
    logic [MIDX_W-1:0] hmaster_data_q;
    logic              hmastlock_q;
    logic [7:0]        hold_cnt_q, hold_cnt_d;

    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] cand;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   others_req;
    logic                   quota_expired;
    logic [MIDX_W-1:0]      pick_idx;
    logic                   pick_found;

    assign owner_oh      = NUM_MASTERS'(1) << grant_idx_q;
    assign owner_req     = HBUSREQ[grant_idx_q];
    assign owner_lock    = owner_req & HLOCK[grant_idx_q];
    assign others_req    = |(HBUSREQ & ~owner_oh);
    assign quota_expired = (hold_cnt_q >= HOLD_MAX);

    // Hand-over candidates: an owner whose quota ran out steps aside while
    // someone else is waiting.
    always_comb begin
        cand = HBUSREQ;
        if (quota_expired && others_req) begin
            cand = HBUSREQ & ~owner_oh;
        end
    end

`ifdef AHB_ARB_ROUND_ROBIN_EN
    // Search starts just after the owner and wraps, so the owner is last.
    always_comb begin
        pick_idx   = DEF_IDX;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int j;
            j = (int'(grant_idx_q) + k) % NUM_MASTERS;
            if (!pick_found && cand[MIDX_W'(j)]) begin
                pick_idx   = MIDX_W'(j);
                pick_found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        pick_idx   = DEF_IDX;
        pick_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (cand[MIDX_W'(i)]) begin
                pick_idx   = MIDX_W'(i);
                pick_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        grant_idx_d = grant_idx_q;
        if (owner_lock) begin
            grant_idx_d = grant_idx_q;
        end else if (owner_req && (!quota_expired || !others_req)) begin
            grant_idx_d = grant_idx_q;
        end else if (pick_found) begin
            grant_idx_d = pick_idx;
        end else begin
            grant_idx_d = DEF_IDX;
        end
    end

    // Quota counter restarts on every hand-over and stays at zero through a
    // locked sequence, so dropping the lock starts a fresh quota.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (grant_idx_d != grant_idx_q || owner_lock) begin
            hold_cnt_d = 8'd0;
        end else if (owner_req && hold_cnt_q < HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_idx_q    <= DEF_IDX;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            hmastlock_q    <= 1'b0;
            hold_cnt_q     <= 8'd0;
        end else if (HREADY) begin
            grant_idx_q    <= grant_idx_d;
            hmaster_q      <= grant_idx_q;
            hmaster_data_q <= hmaster_q;
            hmastlock_q    <= owner_lock;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign HGRANT       = owner_oh;
    assign HMASTER      = hmaster_q;
    assign HMASTER_DATA = hmaster_data_q;
    assign HMASTLOCK    = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the arbitration rules.
module tb_ahb_bus_arbiter;

    localparam int N    = 3;
    localparam int W    = 2;
    localparam int DEF  = 0;
    localparam int MAXH = 4;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic         HREADY;
    logic [N-1:0] HGRANT;
    logic [W-1:0] HMASTER;
    logic [W-1:0] HMASTER_DATA;
    logic         HMASTLOCK;

    ahb_bus_arbiter #(
        .NUM_MASTERS(N), .MIDX_W(W), .DEFAULT_MASTER(DEF), .MAX_HOLD(MAXH)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
        .HMASTER_DATA(HMASTER_DATA), .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit model_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_own, m_cnt, m_hm, m_hmd, m_hml;
    int others, nxt;
    bit oreq, olk, expired;
    int order[$];

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_own = DEF; m_cnt = 0; m_hm = DEF; m_hmd = DEF; m_hml = 0;
        end else if (HREADY) begin
            oreq    = HBUSREQ[m_own];
            olk     = oreq && HLOCK[m_own];
            others  = 0;
            for (int i = 0; i < N; i++)
                if (i != m_own && HBUSREQ[i]) others++;
            expired = (m_cnt >= MAXH - 1);

            m_hmd = m_hm;
            m_hm  = m_own;
            m_hml = olk ? 1 : 0;

            if (olk) nxt = m_own;
            else if (oreq && (!expired || others == 0)) nxt = m_own;
            else if (HBUSREQ != '0) begin
                order = {};
                for (int k = 0; k < N; k++) begin
                    int idx;
`ifdef AHB_ARB_ROUND_ROBIN_EN
                    idx = (m_own + 1 + k) % N;
`else
                    idx = k;
`endif
                    if (HBUSREQ[idx] && !(idx == m_own && expired && others > 0))
                        order.push_back(idx);
                end
                nxt = order[0];
            end else nxt = DEF;

            if (nxt != m_own || olk) m_cnt = 0;
            else if (oreq && m_cnt < MAXH - 1) m_cnt++;
            m_own = nxt;
        end
    end

    always @(negedge HCLK) begin
        if (model_en) begin
            chk("m_hgrant", int'(HGRANT), 1 << m_own);
            chk("m_hmaster", int'(HMASTER), m_hm);
            chk("m_hmaster_data", int'(HMASTER_DATA), m_hmd);
            chk("m_hmastlock", int'(HMASTLOCK), m_hml);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HREADY = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        model_en = 1'b1;
        chk("rst_hgrant", int'(HGRANT), 1);
        chk("rst_hmaster", int'(HMASTER), 0);
        chk("rst_hmaster_data", int'(HMASTER_DATA), 0);
        chk("rst_hmastlock", int'(HMASTLOCK), 0);

        // Idle parking
        repeat (5) begin
            @(negedge HCLK);
            chk("idle_hgrant", int'(HGRANT), 3'b001);
            chk("idle_hmaster", int'(HMASTER), 0);
            chk("idle_hmaster_data", int'(HMASTER_DATA), 0);
            chk("idle_hmastlock", int'(HMASTLOCK), 0);
        end

        // Grant hand-over and pipeline latency
        HBUSREQ = 3'b010;
        @(negedge HCLK);
        chk("ho_hgrant", int'(HGRANT), 3'b010);
        chk("ho_hmaster0", int'(HMASTER), 0);
        @(negedge HCLK);
        chk("ho_hmaster1", int'(HMASTER), 1);
        chk("ho_hmd0", int'(HMASTER_DATA), 0);
        @(negedge HCLK);
        chk("ho_hmd1", int'(HMASTER_DATA), 1);

        // Back to master 0, then a hand-over stalled by HREADY=0
        HBUSREQ = 3'b001;
        @(negedge HCLK);
        chk("back_hgrant", int'(HGRANT), 3'b001);
        HBUSREQ = 3'b010; HREADY = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            chk("stall_hgrant", int'(HGRANT), 3'b001);
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("stall_release", int'(HGRANT), 3'b010);

        // Quota: owner 1 (just granted) keeps 3 more points, then yields to 0
        HBUSREQ = 3'b011;
        repeat (3) begin
            @(negedge HCLK);
            chk("quota_hold", int'(HGRANT), 3'b010);
        end
        @(negedge HCLK);
        chk("quota_move", int'(HGRANT), 3'b001);

        // Locked sequence on master 2 ignores the quota
        HBUSREQ = 3'b100;
        @(negedge HCLK);
        chk("lk_get", int'(HGRANT), 3'b100);
        HBUSREQ = 3'b111; HLOCK = 3'b100;
        repeat (20) begin
            @(negedge HCLK);
            chk("lk_hgrant", int'(HGRANT), 3'b100);
            chk("lk_hmastlock", int'(HMASTLOCK), 1);
        end
        HLOCK = 3'b000;
        repeat (3) begin
            @(negedge HCLK);
            chk("unlk_hold", int'(HGRANT), 3'b100);
        end
        @(negedge HCLK);
        chk("unlk_move", int'(HGRANT), 3'b001);

        // Randomized traffic; inputs persist a few cycles to build sequences
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) HBUSREQ = N'($urandom);
            if ($urandom_range(0, 5) == 0) HLOCK = N'($urandom);
            HREADY = ($urandom_range(0, 3) != 0);
            HRESET = ($urandom_range(0, 199) == 0);
            @(negedge HCLK);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
